udma_rx_lin_arbiter: RTL and testbench
======================================

// Module: udma_rx_lin_arbiter
// PURPOSE
//  Round-robin arbiter merging the uDMA linear RX channels (UART, QSPIM, I2C, I2S, HYPER, CAM)
//  onto the single L2 write-data stream. Sits between peripheral RX channel outputs and the L2
//  write port. One registered output stage; sustains one beat per cycle under no backpressure.
// PARAMETERS
//  N_CH    4   number of linear RX channels; equals N_RX_LIN_CHANNELS; >=1
//  DATA_W  32  data width per channel beat
//  ID_W    $clog2(N_CH) (min 1)  channel-id width, derived localparam
// PORTS
//  clk_i         in   1          clock
//  rst_i         in   1          synchronous reset, active-high
//  ch_valid_i    in   N_CH       per-channel beat valid
//  ch_data_i     in   N_CH*DATA_W per-channel data, channel i at [i*DATA_W +: DATA_W]
//  ch_size_i     in   N_CH*2     per-channel beat size (0=byte,1=half,2=word)
//  ch_ready_o    out  N_CH       per-channel beat accepted (combinational)
//  out_valid_o   out  1          registered beat valid toward L2
//  out_data_o    out  DATA_W     registered data
//  out_size_o    out  2          registered size
//  out_id_o      out  ID_W       channel index of registered beat
//  out_ready_i   in   1          L2 side accepts beat
//  cnt_clr_i     in   1          clear statistics counters
//  grant_cnt_o   out  N_CH*16    per-channel accepted-beat counters
// BEHAVIOUR
//  - Reset: out_valid_o=0, out_data_o=0, out_size_o=0, out_id_o=0, rr pointer=0, counters=0.
//  - load_en = !out_valid_o | out_ready_i. Output register loads only when load_en.
//  - Arbitration: among ch_valid_i, pick first set index searching ptr, ptr+1, ... wrapping mod
//    N_CH. ch_ready_o[g]=1 for granted g only when load_en; all other bits 0. No request -> all 0.
//  - Handshake per channel: beat transfers when ch_valid_i[i] & ch_ready_o[i]; channel must hold
//    data/size stable while valid and not ready. ch_ready_o never depends on out_valid of same cycle
//    beyond load_en.
//  - On transfer from g: next cycle out_valid_o=1, out_data/size/id = channel g values; ptr <= g+1
//    (wraps to 0 at N_CH). Latency: 1 cycle from accept to out_valid_o.
//  - load_en & no request -> out_valid_o <= 0; data/size/id hold previous values.
//  - Stall (out_valid_o & !out_ready_i): output fields stable, ptr unchanged, all ch_ready_o=0.
//  - Simultaneous out_ready_i and new request: drain and reload same cycle (no bubble).
//  - N_CH=1: ptr stays 0, out_id_o constant 0.
//  - Reset mid-operation: pending registered beat is discarded (not re-presented); ptr returns 0.
// CONFIGURATION
//  - Macro UDMA_RX_ARB_STATS_EN defined: per-channel 16-bit counters increment on each accepted
//    beat of that channel; saturate at 0xFFFF; cnt_clr_i=1 zeroes all counters that cycle,
//    overriding a coincident increment.
//  - Macro undefined: counters not instantiated; grant_cnt_o tied to 0; cnt_clr_i ignored.
//  - Arbitration and datapath identical in both builds.
// TESTING
//  1 Reset: assert rst_i 2 cycles with all ch_valid_i=1 -> out_valid_o=0, ch_ready_o=0 during reset.
//  2 Fairness: N_CH=4, all valid, out_ready_i=1 -> out_id_o 0,1,2,3,0,1... one beat/cycle, first
//    out_valid_o one cycle after reset release + first accept.
//  3 Backpressure: beat from ch1 (data 0xA5A5_0001) held, out_ready_i=0 for 3 cycles -> output
//    stable, ch_ready_o=0; out_ready_i=1 -> next beat loads same cycle, no bubble.
//  4 Single channel: only ch2 valid, out_ready_i=1 -> ch2 granted every cycle, out_id_o=2 continuous.
//  5 Wrap priority: grant ch1, then ch0 and ch3 request together -> ch3 first, then ch0.
//  6 Stats (STATS_EN): 5 ch1 beats -> grant_cnt_o[31:16]=5; 65540 ch0 beats -> 0xFFFF; cnt_clr_i
//    with coincident ch0 beat -> 0. Without macro -> grant_cnt_o always 0.
//  7 Reset mid-stall: out_valid_o=1 stalled, rst_i pulse -> out_valid_o=0, next grant from ch0.

Source files
------------

// File: rtl/udma_rx_lin_arbiter.sv
// udma_rx_lin_arbiter: round-robin merge of the uDMA linear RX channels
// onto the single registered L2 write-data stream.
//
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   ch_valid_i        per-channel beat valid            [N_CH]
//   ch_data_i         per-channel data, ch i at [i*DATA_W +: DATA_W]
//   ch_size_i         per-channel size, ch i at [i*2 +: 2]
//   ch_ready_o        per-channel accept (combinational) [N_CH]
//   out_valid_o       registered beat valid toward L2
//   out_data_o        registered beat data
//   out_size_o        registered beat size
//   out_id_o          channel index of registered beat
//   out_ready_i       L2 side accepts beat
//   cnt_clr_i         clear statistics counters
//   grant_cnt_o       per-channel 16-bit accepted-beat counters
//
// Build option: define UDMA_RX_ARB_STATS_EN to instantiate the saturating
// per-channel counters; otherwise grant_cnt_o is tied to 0.

module udma_rx_lin_arbiter #(
   parameter  int N_CH   = 4,
   parameter  int DATA_W = 32,
   localparam int ID_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [N_CH-1:0]      ch_valid_i,
   input  logic [N_CH*DATA_W-1:0] ch_data_i,
   input  logic [N_CH*2-1:0]    ch_size_i,
   output logic [N_CH-1:0]      ch_ready_o,
   output logic                 out_valid_o,
   output logic [DATA_W-1:0]    out_data_o,
   output logic [1:0]           out_size_o,
   output logic [ID_W-1:0]      out_id_o,
   input  logic                 out_ready_i,
   input  logic                 cnt_clr_i,
   output logic [N_CH*16-1:0]   grant_cnt_o
);

   logic [ID_W-1:0]   ptr_q;
   logic [ID_W-1:0]   ptr_nxt;
   logic [ID_W-1:0]   gnt_idx;
   logic              gnt_any;
   logic              load_en;
   logic              xfer;
   logic [DATA_W-1:0] sel_data;
   logic [1:0]        sel_size;
   int                idx;

   // Search order ptr, ptr+1, ... wrapping modulo N_CH.
   function automatic int wrap_idx(input int p, input int k);
      int s;
      s = p + k;
      if (s >= N_CH) s = s - N_CH;
      return s;
   endfunction

   // Reset gates the handshake so no beat is accepted while in reset.
   assign load_en = (!out_valid_o || out_ready_i) && !rst_i;
   assign xfer    = load_en && gnt_any;

   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      idx     = 0;
      for (int k = 0; k < N_CH; k++) begin
         idx = wrap_idx(int'(ptr_q), k);
         for (int i = 0; i < N_CH; i++) begin
            if (!gnt_any && i == idx && ch_valid_i[i]) begin
               gnt_any = 1'b1;
               gnt_idx = ID_W'(i);
            end
         end
      end
   end

   always_comb begin
      ch_ready_o = '0;
      sel_data   = '0;
      sel_size   = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (gnt_idx == ID_W'(i)) begin
            ch_ready_o[i] = xfer;
            sel_data      = ch_data_i[i*DATA_W +: DATA_W];
            sel_size      = ch_size_i[i*2 +: 2];
         end
      end
   end

   assign ptr_nxt = (gnt_idx == ID_W'(N_CH-1)) ? '0 : gnt_idx + 1'b1;

   // Output register: a stalled beat holds; an empty slot drops valid
   // but keeps the last fields.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         out_valid_o <= 1'b0;
         out_data_o  <= '0;
         out_size_o  <= '0;
         out_id_o    <= '0;
         ptr_q       <= '0;
      end else if (load_en) begin
         out_valid_o <= gnt_any;
         if (gnt_any) begin
            out_data_o <= sel_data;
            out_size_o <= sel_size;
            out_id_o   <= gnt_idx;
            ptr_q      <= ptr_nxt;
         end
      end
   end

`ifdef UDMA_RX_ARB_STATS_EN
   logic [15:0] cnt_q [N_CH];

   // Clear wins over a coincident increment; counters saturate.
   always_ff @(posedge clk_i) begin
      for (int i = 0; i < N_CH; i++) begin
         if (rst_i || cnt_clr_i) begin
            cnt_q[i] <= '0;
         end else if (ch_ready_o[i] && ch_valid_i[i] &&
                      cnt_q[i] != 16'hFFFF) begin
            cnt_q[i] <= cnt_q[i] + 16'd1;
         end
      end
   end

   for (genvar g = 0; g < N_CH; g++) begin : g_cnt
      assign grant_cnt_o[g*16 +: 16] = cnt_q[g];
   end
`else
   logic unused_cnt_clr;
   assign unused_cnt_clr = cnt_clr_i;
   assign grant_cnt_o    = '0;
`endif

endmodule

// File: tb/tb_udma_rx_lin_arbiter.sv
// tb_udma_rx_lin_arbiter: directed bench for the uDMA RX linear arbiter.
// Inputs change #1 after posedge; outputs are checked at negedge.

module tb_udma_rx_lin_arbiter;

   localparam int N_CH   = 4;
   localparam int DATA_W = 32;

   logic                   clk = 1'b0;
   logic                   rst_i;
   logic [N_CH-1:0]        ch_valid_i;
   logic [N_CH*DATA_W-1:0] ch_data_i;
   logic [N_CH*2-1:0]      ch_size_i;
   logic [N_CH-1:0]        ch_ready_o;
   logic                   out_valid_o;
   logic [DATA_W-1:0]      out_data_o;
   logic [1:0]             out_size_o;
   logic [1:0]             out_id_o;
   logic                   out_ready_i;
   logic                   cnt_clr_i;
   logic [N_CH*16-1:0]     grant_cnt_o;

   int checks = 0;
   int errors = 0;

   udma_rx_lin_arbiter #(.N_CH(N_CH), .DATA_W(DATA_W)) dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .ch_valid_i  (ch_valid_i),
      .ch_data_i   (ch_data_i),
      .ch_size_i   (ch_size_i),
      .ch_ready_o  (ch_ready_o),
      .out_valid_o (out_valid_o),
      .out_data_o  (out_data_o),
      .out_size_o  (out_size_o),
      .out_id_o    (out_id_o),
      .out_ready_i (out_ready_i),
      .cnt_clr_i   (cnt_clr_i),
      .grant_cnt_o (grant_cnt_o)
   );

   always #5 clk = ~clk;

   task automatic do_reset();
      @(posedge clk); #1;
      rst_i       = 1'b1;
      ch_valid_i  = '0;
      out_ready_i = 1'b1;
      cnt_clr_i   = 1'b0;
      @(posedge clk); #1;
      rst_i = 1'b0;
   endtask

   task automatic test_reset();
      rst_i       = 1'b1;
      ch_valid_i  = 4'b1111;
      out_ready_i = 1'b1;
      cnt_clr_i   = 1'b0;
      for (int i = 0; i < N_CH; i++) begin
         ch_data_i[i*DATA_W +: DATA_W] = 32'h1000_0000 + i;
         ch_size_i[i*2 +: 2]           = 2'(i % 3);
      end
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         checks++;
         if (out_valid_o !== 1'b0 || ch_ready_o !== 4'b0000) begin
            errors++;
            $display("FAIL reset c%0d: valid=%b ready=%b want 0/0000",
                     c, out_valid_o, ch_ready_o);
         end
      end
      checks++;
      if (out_data_o !== '0 || out_id_o !== 2'd0 || out_size_o !== 2'd0) begin
         errors++;
         $display("FAIL reset_fields: data=%h id=%0d size=%0d want 0",
                  out_data_o, out_id_o, out_size_o);
      end
   endtask

   task automatic test_fairness();
      @(posedge clk); #1;
      rst_i = 1'b0;
      @(negedge clk);
      checks++;
      if (ch_ready_o !== 4'b0001 || out_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL fair_first: ready=%b valid=%b want 0001/0",
                  ch_ready_o, out_valid_o);
      end
      for (int j = 1; j <= 8; j++) begin
         @(negedge clk);
         checks++;
         if (out_valid_o !== 1'b1 || out_id_o !== 2'((j-1) % 4) ||
             out_data_o !== 32'h1000_0000 + (j-1) % 4 ||
             out_size_o !== 2'(((j-1) % 4) % 3) ||
             ch_ready_o !== 4'(1 << (j % 4))) begin
            errors++;
            $display("FAIL fair_%0d: v=%b id=%0d d=%h sz=%0d rdy=%b want id=%0d",
                     j, out_valid_o, out_id_o, out_data_o, out_size_o,
                     ch_ready_o, (j-1) % 4);
         end
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      ch_data_i[1*DATA_W +: DATA_W] = 32'hA5A5_0001;
      ch_valid_i = 4'b0010;
      @(posedge clk); #1;
      out_ready_i = 1'b0;
      ch_data_i[1*DATA_W +: DATA_W] = 32'hA5A5_0002;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++;
         if (out_valid_o !== 1'b1 || out_data_o !== 32'hA5A5_0001 ||
             out_id_o !== 2'd1 || ch_ready_o !== 4'b0000) begin
            errors++;
            $display("FAIL stall_%0d: v=%b d=%h id=%0d rdy=%b want 1/a5a50001/1/0000",
                     c, out_valid_o, out_data_o, out_id_o, ch_ready_o);
         end
         if (c < 2) @(posedge clk);
      end
      @(posedge clk); #1;
      out_ready_i = 1'b1;
      @(negedge clk);
      checks++;
      if (ch_ready_o !== 4'b0010) begin
         errors++;
         $display("FAIL bp_reload_ready: rdy=%b want 0010", ch_ready_o);
      end
      @(posedge clk); #1;
      ch_valid_i = '0;
      @(negedge clk);
      checks++;
      if (out_valid_o !== 1'b1 || out_data_o !== 32'hA5A5_0002) begin
         errors++;
         $display("FAIL bp_second: v=%b d=%h want 1/a5a50002",
                  out_valid_o, out_data_o);
      end
      @(negedge clk);
      checks++;
      if (out_valid_o !== 1'b0 || out_data_o !== 32'hA5A5_0002 ||
          out_id_o !== 2'd1) begin
         errors++;
         $display("FAIL bp_idle_hold: v=%b d=%h id=%0d want 0/a5a50002/1",
                  out_valid_o, out_data_o, out_id_o);
      end
   endtask

   task automatic test_single_channel();
      do_reset();
      ch_valid_i = 4'b0100;
      @(negedge clk);
      checks++;
      if (ch_ready_o !== 4'b0100) begin
         errors++;
         $display("FAIL single_first: rdy=%b want 0100", ch_ready_o);
      end
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checks++;
         if (out_valid_o !== 1'b1 || out_id_o !== 2'd2 ||
             ch_ready_o !== 4'b0100) begin
            errors++;
            $display("FAIL single_%0d: v=%b id=%0d rdy=%b want 1/2/0100",
                     c, out_valid_o, out_id_o, ch_ready_o);
         end
      end
   endtask

   task automatic test_wrap_priority();
      do_reset();
      ch_valid_i = 4'b0010;
      @(posedge clk); #1;
      ch_valid_i = 4'b1001;
      @(negedge clk);
      checks++;
      if (ch_ready_o !== 4'b1000 || out_id_o !== 2'd1) begin
         errors++;
         $display("FAIL wrap_ch3: rdy=%b id=%0d want 1000/1",
                  ch_ready_o, out_id_o);
      end
      @(posedge clk); #1;
      ch_valid_i = 4'b0001;
      @(negedge clk);
      checks++;
      if (ch_ready_o !== 4'b0001 || out_id_o !== 2'd3) begin
         errors++;
         $display("FAIL wrap_ch0: rdy=%b id=%0d want 0001/3",
                  ch_ready_o, out_id_o);
      end
      @(posedge clk); #1;
      ch_valid_i = '0;
      @(negedge clk);
      checks++;
      if (out_valid_o !== 1'b1 || out_id_o !== 2'd0) begin
         errors++;
         $display("FAIL wrap_out0: v=%b id=%0d want 1/0",
                  out_valid_o, out_id_o);
      end
   endtask

   task automatic test_stats();
      do_reset();
`ifdef UDMA_RX_ARB_STATS_EN
      ch_valid_i = 4'b0010;
      repeat (5) @(posedge clk);
      #1 ch_valid_i = '0;
      @(negedge clk);
      checks++;
      if (grant_cnt_o[31:16] !== 16'd5) begin
         errors++;
         $display("FAIL stats_ch1: cnt=%0d want 5", grant_cnt_o[31:16]);
      end
      ch_valid_i = 4'b0001;
      repeat (65540) @(posedge clk);
      @(negedge clk);
      checks++;
      if (grant_cnt_o[15:0] !== 16'hFFFF) begin
         errors++;
         $display("FAIL stats_sat: cnt=%h want ffff", grant_cnt_o[15:0]);
      end
      @(posedge clk); #1;
      cnt_clr_i = 1'b1;
      @(posedge clk); #1;
      cnt_clr_i = 1'b0;
      ch_valid_i = '0;
      @(negedge clk);
      checks++;
      if (grant_cnt_o !== '0) begin
         errors++;
         $display("FAIL stats_clr: cnt=%h want 0", grant_cnt_o);
      end
`else
      ch_valid_i = 4'b0011;
      repeat (6) @(posedge clk);
      @(negedge clk);
      checks++;
      if (grant_cnt_o !== '0) begin
         errors++;
         $display("FAIL stats_off: cnt=%h want 0", grant_cnt_o);
      end
      #4 cnt_clr_i = 1'b1;
      @(posedge clk); #1;
      cnt_clr_i = 1'b0;
      ch_valid_i = '0;
      @(negedge clk);
      checks++;
      if (grant_cnt_o !== '0) begin
         errors++;
         $display("FAIL stats_off_clr: cnt=%h want 0", grant_cnt_o);
      end
`endif
   endtask

   task automatic test_reset_mid_stall();
      do_reset();
      ch_valid_i = 4'b0100;
      @(posedge clk); #1;
      out_ready_i = 1'b0;
      ch_valid_i  = '0;
      @(negedge clk);
      checks++;
      if (out_valid_o !== 1'b1 || out_id_o !== 2'd2) begin
         errors++;
         $display("FAIL rst_stall_pre: v=%b id=%0d want 1/2",
                  out_valid_o, out_id_o);
      end
      @(posedge clk); #1;
      rst_i      = 1'b1;
      ch_valid_i = 4'b1111;
      @(negedge clk);
      checks++;
      if (ch_ready_o !== 4'b0000) begin
         errors++;
         $display("FAIL rst_stall_rdy: rdy=%b want 0000", ch_ready_o);
      end
      @(posedge clk); #1;
      rst_i = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid_o !== 1'b0 || ch_ready_o !== 4'b0001) begin
         errors++;
         $display("FAIL rst_stall_post: v=%b rdy=%b want 0/0001",
                  out_valid_o, ch_ready_o);
      end
      @(posedge clk); #1;
      ch_valid_i  = '0;
      out_ready_i = 1'b1;
      @(negedge clk);
      checks++;
      if (out_valid_o !== 1'b1 || out_id_o !== 2'd0) begin
         errors++;
         $display("FAIL rst_stall_next: v=%b id=%0d want 1/0",
                  out_valid_o, out_id_o);
      end
   endtask

   initial begin
      test_reset();
      test_fairness();
      test_backpressure();
      test_single_channel();
      test_wrap_priority();
      test_stats();
      test_reset_mid_stall();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
